// File: rtl/apb_mem_slave_if.sv
// APB bus bundle for apb_mem_slave: the master drives the request, the slave
// returns PREADY/PRDATA/PSLVERR.
interface apb_mem_slave_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_mem_slave.sv
// APB slave backed by a MEM_DEPTH-entry register memory that is cleared on reset.
// Defining APB_SLV_WAIT_EN inserts WAIT_CYCLES wait states into every access.
//
// state  | meaning
// IDLE   | no transfer in progress, waiting for a setup phase (PSEL=1, PENABLE=0)
// ACCESS | setup accepted, waiting out wait states, then completing on PREADY=1
module apb_mem_slave #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             i_pclk,
  input  logic             i_presetn,
  apb_mem_slave_if.slave   apb
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;
  localparam int         IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [0:0]        r_state;
  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  logic             w_setup;
  logic             w_access;
  logic             w_cnt_zero;
  logic             w_pready;
  logic             w_in_range;
  logic [IDX_W-1:0] w_idx;

  assign w_setup    = (r_state == ST_IDLE) && apb.psel && !apb.penable;
  assign w_access   = (r_state == ST_ACCESS) && apb.psel && apb.penable;
  assign w_pready   = w_access && w_cnt_zero;
  assign w_in_range = (32'(apb.paddr) < 32'(MEM_DEPTH));
  assign w_idx      = apb.paddr[IDX_W-1:0];

`ifdef APB_SLV_WAIT_EN
  logic [3:0] r_wait_cnt;

  assign w_cnt_zero = (r_wait_cnt == 4'd0);

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      r_wait_cnt <= 4'd0;
    end else if (w_setup) begin
      r_wait_cnt <= 4'(WAIT_CYCLES);
    end else if (w_access && !w_cnt_zero) begin
      r_wait_cnt <= r_wait_cnt - 4'd1;
    end
  end
`else
  // No wait counter in this build: every access completes in its first cycle.
  logic w_unused_wait;
  assign w_unused_wait = (WAIT_CYCLES != 0);
  assign w_cnt_zero    = 1'b1;
`endif

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_setup) r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // Dropping PSEL before completion abandons the transfer.
          if (!apb.psel || w_pready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_pready && apb.pwrite && w_in_range) begin
      r_mem[w_idx] <= apb.pwdata;
    end
  end

  assign apb.pready  = w_pready;
  assign apb.pslverr = w_pready && !w_in_range;
  assign apb.prdata  = (w_pready && !apb.pwrite && w_in_range) ? r_mem[w_idx] : '0;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: the driver queues the expected completion
// of each transfer and a negedge monitor checks it whenever PREADY is seen.
module tb_apb_mem_slave;

  localparam int WAITC = 2;
`ifdef APB_SLV_WAIT_EN
  localparam int EXP_ACC = WAITC + 1;
`else
  localparam int EXP_ACC = 1;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       e;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  exp_t exp_q[$];

  apb_mem_slave_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  apb_mem_slave #(
    .ADDR_W(8), .DATA_W(8), .MEM_DEPTH(64), .WAIT_CYCLES(WAITC)
  ) dut (
    .i_pclk    (clk),
    .i_presetn (rst_n),
    .apb       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.pready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_pready: got pready=1 expected none, addr=%0h", bus.paddr);
        end else begin
          e = exp_q.pop_front();
          chk("prdata", bus.prdata, e.d);
          chk("pslverr", {7'b0, bus.pslverr}, {7'b0, e.e});
        end
      end
    end
  end

  // Entered and left at posedge+1.
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] exp_d, input logic exp_e);
    int cyc;
    exp_q.push_back('{d: exp_d, e: exp_e});
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = a; bus.pwdata = d;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.pready === 1'b1) break;
      if (cyc >= 32) begin
        n_cmp++;
        n_fail++;
        $display("FAIL timeout: got no pready after %0d cycles expected %0d", cyc, EXP_ACC);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("access_cycles", 8'(cyc), 8'(EXP_ACC));
  endtask

  task automatic idle(input int n);
    bus.psel = 1'b0; bus.penable = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = 8'h00; bus.pwdata = 8'h00;
    #12;
    chk("rst_pready", {7'b0, bus.pready}, 8'h00);
    chk("rst_pslverr", {7'b0, bus.pslverr}, 8'h00);
    chk("rst_prdata", bus.prdata, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write / read back
    xfer(1'b1, 8'h10, 8'hA5, 8'h00, 1'b0);
    idle(1);
    xfer(1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);
    idle(1);

    // Top in-range address
    xfer(1'b1, 8'h3F, 8'h3C, 8'h00, 1'b0);
    xfer(1'b0, 8'h3F, 8'h00, 8'h3C, 1'b0);
    idle(1);

    // Out of range: error, no aliasing into low memory
    xfer(1'b1, 8'h40, 8'hFF, 8'h00, 1'b1);
    xfer(1'b0, 8'h40, 8'h00, 8'h00, 1'b1);
    xfer(1'b1, 8'hFF, 8'hEE, 8'h00, 1'b1);
    xfer(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    xfer(1'b0, 8'h3F, 8'h00, 8'h3C, 1'b0);
    idle(1);

    // Abort: PSEL dropped in the access phase
    xfer(1'b1, 8'h01, 8'h5A, 8'h00, 1'b0);
    idle(1);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 8'h01; bus.pwdata = 8'h77;
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b1;
    @(negedge clk);
    chk("abort_pready", {7'b0, bus.pready}, 8'h00);
    @(posedge clk); #1;
    idle(1);
    xfer(1'b0, 8'h01, 8'h00, 8'h5A, 1'b0);
    idle(1);

    // PENABLE without a setup phase is ignored
    bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b1; bus.paddr = 8'h03; bus.pwdata = 8'h99;
    repeat (2) begin
      @(negedge clk);
      chk("viol_pready", {7'b0, bus.pready}, 8'h00);
      @(posedge clk); #1;
    end
    idle(1);
    xfer(1'b0, 8'h03, 8'h00, 8'h00, 1'b0);
    idle(1);

    // Back-to-back write then read
    xfer(1'b1, 8'h02, 8'h11, 8'h00, 1'b0);
    xfer(1'b0, 8'h02, 8'h00, 8'h11, 1'b0);
    idle(1);

    // Reset in the middle of a read access
    xfer(1'b1, 8'h05, 8'h66, 8'h00, 1'b0);
    idle(1);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 8'h05;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    if (EXP_ACC == 1) begin
      #1;
      chk("pre_rst_pready", {7'b0, bus.pready}, 8'h01);
      chk("pre_rst_prdata", bus.prdata, 8'h66);
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pready", {7'b0, bus.pready}, 8'h00);
    chk("mid_rst_pslverr", {7'b0, bus.pslverr}, 8'h00);
    chk("mid_rst_prdata", bus.prdata, 8'h00);
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1'b0, 8'h05, 8'h00, 8'h00, 1'b0);
    xfer(1'b0, 8'h10, 8'h00, 8'h00, 1'b0);
    idle(3);

    chk("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
